// File: rtl/exe_mem_skid_reg.sv
// exe_mem_skid_reg: EXE->MEM two-entry skid register with valid/ready handshake and NZCV ownership
module exe_mem_skid_reg #(
    parameter int DATA_W = 32,
    parameter int SR_W   = 4,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [SR_W-1:0]   alu_sr,
    input  logic              s_bit,
    input  logic [REG_W-1:0]  dest,
    input  logic              wb_en,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [DATA_W-1:0] st_val,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [REG_W-1:0]  out_dest,
    output logic              out_wb_en,
    output logic              out_mem_r_en,
    output logic              out_mem_w_en,
    output logic [DATA_W-1:0] out_st_val,
    output logic [SR_W-1:0]   status_reg,
    output logic              status_c
);
    localparam int P_W = 2*DATA_W + REG_W + 3;
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    state_t state, state_nx;
    logic [P_W-1:0] head, skid, head_nx, skid_nx, in_p;
    logic accept, pop;
    assign in_p = {alu_result, dest, wb_en, mem_r_en, mem_w_en, st_val};
    assign accept = in_valid & in_ready & ~flush;
    assign out_valid = state != EMPTY;
    assign pop = out_valid & out_ready;
    assign {out_result, out_dest, out_wb_en, out_mem_r_en, out_mem_w_en, out_st_val} = head;
    assign status_c = status_reg[1];
    always_comb begin
        state_nx = state;
        head_nx  = head;
        skid_nx  = skid;
        if (flush) begin
            state_nx = EMPTY;
            head_nx  = '0;
            skid_nx  = '0;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    state_nx = ONE;
                    head_nx  = in_p;
                end
                ONE: if (accept && pop) begin
                    head_nx = in_p;
                end else if (accept) begin
                    state_nx = TWO;
                    skid_nx  = in_p;
                end else if (pop) begin
                    state_nx = EMPTY;
                    head_nx  = '0;
                end
                TWO: if (pop) begin
                    state_nx = ONE;
                    head_nx  = skid;
                    skid_nx  = '0;
                end
                default: begin
                    state_nx = EMPTY;
                    head_nx  = '0;
                    skid_nx  = '0;
                end
            endcase
        end
    end
    // in_ready follows the next state so a full buffer never sees a third accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= EMPTY;
            head       <= '0;
            skid       <= '0;
            in_ready   <= 1'b1;
            status_reg <= '0;
        end else begin
            state    <= state_nx;
            head     <= head_nx;
            skid     <= skid_nx;
            in_ready <= state_nx != TWO;
            if (accept && s_bit)
                status_reg <= alu_sr;
        end
    end
endmodule

// File: tb/tb_exe_mem_skid_reg.sv
// tb_exe_mem_skid_reg: directed and randomized checks of exe_mem_skid_reg against a queue model
module tb_exe_mem_skid_reg;
    logic        clk, rst, in_valid, in_ready, s_bit, wb_en, mem_r_en, mem_w_en, flush;
    logic        out_valid, out_ready, out_wb_en, out_mem_r_en, out_mem_w_en, status_c;
    logic [31:0] alu_result, st_val, out_result, out_st_val;
    logic [3:0]  alu_sr, dest, out_dest, status_reg;
    int checks = 0, errors = 0;
    logic [70:0] q[$];
    logic [3:0]  m_sr;
    logic        m_zero;

    exe_mem_skid_reg dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .alu_sr(alu_sr), .s_bit(s_bit), .dest(dest),
        .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .st_val(st_val),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_dest(out_dest), .out_wb_en(out_wb_en),
        .out_mem_r_en(out_mem_r_en), .out_mem_w_en(out_mem_w_en),
        .out_st_val(out_st_val), .status_reg(status_reg), .status_c(status_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: a FIFO of at most two payloads plus a flag register
    initial begin
        logic acc, pp;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                q.delete();
                m_sr = '0;
                m_zero = 1'b1;
            end else begin
                acc = in_valid && q.size() < 2 && !flush;
                pp  = q.size() > 0 && out_ready;
                if (flush) begin
                    q.delete();
                    m_zero = 1'b1;
                end else begin
                    if (pp) void'(q.pop_front());
                    if (acc) begin
                        q.push_back({alu_result, dest, wb_en, mem_r_en, mem_w_en, st_val});
                        m_zero = 1'b0;
                    end
                end
                if (acc && s_bit) m_sr = alu_sr;
            end
        end
    end

    always @(negedge clk) begin
        logic [70:0] dp;
        dp = {out_result, out_dest, out_wb_en, out_mem_r_en, out_mem_w_en, out_st_val};
        chk("m_out_valid", out_valid, q.size() > 0);
        chk("m_in_ready", in_ready, q.size() < 2);
        chk("m_status", status_reg, m_sr);
        chk("m_status_c", status_c, m_sr[1]);
        if (q.size() > 0) chk("m_payload", dp, q[0]);
        else if (m_zero) chk("m_payload_zero", dp, 0);
    end

    task automatic cyc(input logic iv, input logic [31:0] res, input logic [3:0] sr,
                       input logic sb, input logic fl, input logic ordy);
        in_valid = iv; alu_result = res; alu_sr = sr; s_bit = sb; flush = fl; out_ready = ordy;
        dest = 4'($urandom); wb_en = 1'($urandom); mem_r_en = 1'($urandom);
        mem_w_en = 1'($urandom); st_val = $urandom;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b1; alu_result = 32'd99; alu_sr = 4'hF; s_bit = 1'b1;
        dest = '0; wb_en = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0; st_val = '0;
        flush = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_status", status_reg, 0);
        rst = 1'b1;
        cyc(1, 32'd28, 0, 0, 0, 0);
        chk("t1_valid", out_valid, 1);
        chk("t1_result", out_result, 28);
        cyc(1, 32'd29, 0, 0, 0, 1);
        chk("t2_r29", out_result, 29);
        chk("t2_ready", in_ready, 1);
        cyc(1, ~32'd2, 0, 0, 0, 1);
        chk("t2_rfd", out_result, 32'hFFFF_FFFD);
        chk("t2_ready2", in_ready, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("t2_empty", out_valid, 0);
        cyc(1, 32'hA, 0, 0, 0, 0);
        cyc(1, 32'hB, 0, 0, 0, 0);
        chk("t3_ready0", in_ready, 0);
        chk("t3_headA", out_result, 32'hA);
        cyc(0, 0, 0, 0, 0, 1);
        chk("t3_popB", out_result, 32'hB);
        chk("t3_ready1", in_ready, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(1, 32'd5, 4'b0010, 1, 0, 1);
        chk("t4_sr", status_reg, 4'b0010);
        chk("t4_c", status_c, 1);
        cyc(1, 32'd6, 4'b1000, 0, 0, 1);
        chk("t4_hold", status_reg, 4'b0010);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(1, 32'd7, 0, 0, 0, 0);
        cyc(1, 32'd8, 0, 0, 0, 0);
        cyc(1, 32'd9, 4'b0100, 1, 1, 0);
        chk("t5_valid", out_valid, 0);
        chk("t5_ready", in_ready, 1);
        chk("t5_sr", status_reg, 4'b0010);
        chk("t5_result", out_result, 0);
        cyc(1, 32'd10, 0, 0, 0, 0);
        cyc(1, 32'd11, 0, 0, 0, 0);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_ready", in_ready, 1);
        chk("t6_result", out_result, 0);
        chk("t6_sr", status_reg, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 9) < 7, $urandom, 4'($urandom), $urandom_range(0, 9) < 3,
                $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
